// File: rtl/sw_cond.sv
// -----------------------------------------------------------------------------
// sw_cond -- push-button conditioner
//
// Turns raw, bouncing, asynchronous active-low switches into clean single-clk
// events in the clk domain. It also adds hold detection and auto-repeat.
// Everything runs on clk; the sample tick is a clock enable, not a derived clock.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_sw       raw switches, 0 = pressed, asynchronous to clk
//   i_rpt_en   per-switch auto-repeat enable (level)
//   o_level    debounced state, 1 = pressed
//   o_press    one-clk pulse on debounced press
//   o_release  one-clk pulse on debounced release
//   o_repeat   one-clk auto-repeat pulse
//   o_long     high while held for at least REPEAT_DLY ticks
// -----------------------------------------------------------------------------
module sw_cond #(
  parameter int N_SW       = 4,
  parameter int TICK_DIV   = 500000,
  parameter int DB_TICKS   = 2,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] i_sw,
  input  logic [N_SW-1:0] i_rpt_en,
  output logic [N_SW-1:0] o_level,
  output logic [N_SW-1:0] o_press,
  output logic [N_SW-1:0] o_release,
  output logic [N_SW-1:0] o_repeat,
  output logic [N_SW-1:0] o_long
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam int HW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DLY - 1);
  // Reloading to REPEAT_DLY-REPEAT_PER makes the next hit REPEAT_PER ticks away.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DLY - REPEAT_PER);

  logic [N_SW-1:0]          sync1_r;
  logic [N_SW-1:0]          sync2_r;
  logic [TW-1:0]            tick_cnt_r;
  logic [N_SW-1:0][DW-1:0]  db_cnt_r;
  logic [N_SW-1:0][HW-1:0]  hold_cnt_r;

  logic                     tick_s;
  logic [N_SW-1:0]          pressed_s;
  logic [N_SW-1:0]          disagree_s;
  logic [N_SW-1:0]          db_done_s;
  logic [N_SW-1:0]          hold_hit_s;

  // Decode the tick and the per-switch debounce/hold comparisons.
  always_comb begin
    tick_s     = (tick_cnt_r == TICK_LAST);
    pressed_s  = ~sync2_r;
    disagree_s = pressed_s ^ o_level;
    db_done_s  = '0;
    hold_hit_s = '0;
    for (int k = 0; k < N_SW; k++) begin
      db_done_s[k]  = disagree_s[k] && (db_cnt_r[k] == DB_LAST);
      hold_hit_s[k] = (hold_cnt_r[k] == HOLD_LAST);
    end
  end

  // Two-flop synchroniser. It resets to "released" so that a key held through
  // reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= i_sw;
      sync2_r <= sync1_r;
    end
  end

  // Sample-tick divider: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Per-switch debounce, edge pulses and hold/auto-repeat. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r   <= '0;
      hold_cnt_r <= '0;
      o_level    <= '0;
      o_press    <= '0;
      o_release  <= '0;
      o_repeat   <= '0;
      o_long     <= '0;
    end else begin
      o_press   <= '0;
      o_release <= '0;
      o_repeat  <= '0;
      if (tick_s) begin
        for (int k = 0; k < N_SW; k++) begin
          if (db_done_s[k]) begin
            // Debounced flip. The flip tick does not count towards the hold time.
            db_cnt_r[k] <= '0;
            o_level[k]  <= ~o_level[k];
            if (o_level[k]) begin
              o_release[k]  <= 1'b1;
              o_long[k]     <= 1'b0;
              hold_cnt_r[k] <= '0;
            end else begin
              o_press[k]    <= 1'b1;
            end
          end else begin
            if (disagree_s[k]) begin
              db_cnt_r[k] <= db_cnt_r[k] + DW'(1);
            end else begin
              db_cnt_r[k] <= '0;
            end
            if (o_level[k]) begin
              if (hold_hit_s[k]) begin
                // The enable gates only the pulse. Counting and o_long carry on.
                o_long[k]     <= 1'b1;
                hold_cnt_r[k] <= HOLD_RELOAD;
                o_repeat[k]   <= i_rpt_en[k];
              end else begin
                hold_cnt_r[k] <= hold_cnt_r[k] + HW'(1);
              end
            end else begin
              hold_cnt_r[k] <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/sw_cond.md
Name: sw_cond

Overview:
- Push-button conditioner that sits directly upstream of the clock controller's mode/position/increment/alarm-enable inputs.
- Converts raw, bouncing, asynchronous active-low switches into clean single-clk event pulses, all in the clk domain. No derived clocks.
- Adds hold detection and auto-repeat, so a held increment key steps the setup counters repeatedly.

Parameters:
- N_SW, 4: number of switches.
- TICK_DIV, 500000: clk cycles per sample tick (100 Hz at 50 MHz). Minimum 2.
- DB_TICKS, 2: consecutive disagreeing samples required to change the debounced state. Minimum 1.
- REPEAT_DLY, 50: ticks from press to first repeat pulse (0.5 s).
- REPEAT_PER, 10: ticks between subsequent repeat pulses (0.1 s). Constraint: 1 <= REPEAT_PER <= REPEAT_DLY.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- i_sw  in  N_SW  raw switches; 0 = pressed. Asynchronous to clk.
- i_rpt_en  in  N_SW  per-switch auto-repeat enable (level, sampled synchronously).
- o_level  out  N_SW  debounced state; 1 = pressed.
- o_press  out  N_SW  one-clk pulse on debounced press.
- o_release  out  N_SW  one-clk pulse on debounced release.
- o_repeat  out  N_SW  one-clk auto-repeat pulse.
- o_long  out  N_SW  high while held for at least REPEAT_DLY ticks.

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - Sync flops = 1 (released); tick counter = 0; all debounce counters and hold counters = 0.
  - All outputs = 0.
  - A switch held through reset is re-detected as a new press after DB_TICKS ticks, giving one o_press.
- Synchroniser: 2-flop chain per bit; s = ~sync2 (1 = pressed). Adds 2 clk latency.
- Tick: counter runs 0..TICK_DIV-1, wraps. tick = 1 for the single clk where count == TICK_DIV-1. All debounce and hold logic below advances only on tick.
- Debounce, per switch k, on tick:
  - If s[k] != o_level[k]: db_cnt++. When db_cnt reaches DB_TICKS-1 on this tick, the state flips on this tick and db_cnt <= 0.
  - If s[k] == o_level[k]: db_cnt <= 0 (any agreeing sample restarts the count).
  - Therefore a change needs DB_TICKS consecutive disagreeing ticks.
- Press/release pulses (registered):
  - Flip 0->1: o_level[k] rises and o_press[k] = 1 in the same clk cycle, for exactly one clk.
  - Flip 1->0: o_level[k] falls, o_release[k] = 1 for one clk; o_long[k] <= 0 and hold_cnt <= 0 in the same cycle.
- Hold/repeat, per switch, on tick while o_level[k] = 1 (the flip tick itself does not count):
  - If hold_cnt == REPEAT_DLY-1: o_long[k] <= 1, hold_cnt <= REPEAT_DLY-REPEAT_PER, and o_repeat[k] pulses for one clk if i_rpt_en[k] = 1.
  - Otherwise: hold_cnt++.
  - First repeat comes REPEAT_DLY ticks after the press; then one every REPEAT_PER ticks. hold_cnt never exceeds REPEAT_DLY-1, so no wrap issue.
  - Counter width = clog2(REPEAT_DLY).
- i_rpt_en deasserted mid-hold suppresses o_repeat only; counting and o_long are unaffected.
- o_press and o_repeat never fire in the same cycle: the first repeat is at least 1 tick after the press.
- Switches are fully independent; simultaneous events on several bits produce simultaneous pulses.
- Output latency, input edge to o_press: 2 clk + up to DB_TICKS ticks.

Test Plan (TICK_DIV=4, DB_TICKS=3, REPEAT_DLY=8, REPEAT_PER=2):
1. Reset: drive rst_n=0, i_sw=4'hF. All outputs = 0. Release reset and run 100 clk -> still all 0.
2. Clean press: i_sw[0]=0 held for 10 ticks, then 1.
   - Exactly one o_press[0] pulse, within 2 clk + 3 ticks (<= 14 clk) of the edge.
   - o_level[0] = 1 from that cycle.
   - On release: exactly one o_release[0] pulse; o_level[0] = 0.
3. Bounce: toggle i_sw[1] on every tick for 6 ticks, and separately a 2-tick-wide low glitch -> o_level[1], o_press[1] and o_release[1] stay 0.
4. Auto-repeat: i_rpt_en[2]=1, hold i_sw[2] for 20 ticks after the press.
   - o_repeat[2] pulses at press+8, 10, 12, 14, 16, 18, 20 ticks (7 pulses).
   - o_long[2] = 1 from press+8 ticks until o_release[2].
   - Repeat with i_rpt_en[2]=0 -> 0 repeat pulses, o_long[2] timing identical.
5. Simultaneous: press i_sw[0] and i_sw[3] in the same clk -> o_press[0] and o_press[3] pulse in the same cycle, one each; other bits remain 0.
6. Reset mid-hold: assert rst_n low at press+5 ticks while the switch is still held.
   - Outputs clear immediately; no repeat pulse occurs.
   - After release of reset: one new o_press after 3 ticks; first repeat 8 ticks after that.
